ann_layer_sequencer: RTL and testbench
======================================

Name: ann_layer_sequencer

Overview:
- Per-layer input sequencer for the ANN datapath.
- On a start pulse from the ANN controller, clears the node accumulators, then steps a shared input/coefficient read address from 0 to max_input-1 with a ready handshake toward the buffers.
- Delays each accepted read by the memory latency to produce MAC enables.
- Pulses layer_done once the last product has entered the accumulators. The controller waits on this pulse before advancing the layer.

Parameters:
- ADDR_W, 7, width of max_input, rd_addr and mac_idx
- MEM_LATENCY, 1, cycles from an accepted read (rd_en & data_ready) to its data at the MAC inputs; legal range 1..4

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a layer; ignored unless state is IDLE
- max_input  in  ADDR_W  number of inputs for this layer; sampled only when start is accepted
- data_ready  in  1  buffer accepts the read this cycle; may deassert at any time (stall)
- abort  in  1  synchronous abandon of the current layer
- acc_clear  out  1  clear all node accumulators (one cycle)
- rd_en  out  1  read request to the input and coefficient buffers
- rd_addr  out  ADDR_W  input index being read
- mac_en  out  1  accumulate enable, aligned with buffer data
- mac_idx  out  ADDR_W  index of the data currently qualified by mac_en
- busy  out  1  state != IDLE
- layer_done  out  1  one-cycle pulse when all products are accumulated

Behaviour:
- Reset: state=IDLE, lim=0, idx=0; latency pipeline cleared. All outputs are 0, including rd_addr and mac_idx.
- States:
  - IDLE: start → CLEAR, with lim <= max_input and idx <= 0.
  - CLEAR: acc_clear=1 for exactly one cycle. Then go to DONE if lim==0, else to ISSUE.
  - ISSUE: rd_en=1 and rd_addr=idx. A read is accepted when rd_en & data_ready:
    - on accept with idx==lim-1 → DRAIN;
    - on accept otherwise, idx++;
    - on no accept, idx holds and rd_en stays 1 (no dropped or duplicated index).
  - DRAIN: rd_en=0. Hold for exactly MEM_LATENCY cycles (internal down-counter), then → DONE.
  - DONE: layer_done=1 for one cycle → IDLE.
- Latency pipeline: a MEM_LATENCY-deep shift register of {valid, idx}, loaded with {accept, rd_addr} every cycle. mac_en and mac_idx are taken from the last stage.
- The pipeline keeps shifting while data_ready is low, so gaps in mac_en mirror the stall gaps.
- Invariants:
  - exactly lim mac_en pulses per layer, with mac_idx strictly 0..lim-1 in order;
  - the last mac_en occurs in the final DRAIN cycle, one cycle before layer_done;
  - acc_clear always precedes the first mac_en.
- Width: idx compare uses lim-1 only when lim != 0. max_input = 2^ADDR_W-1 (127) is legal; idx never wraps.
- start while busy: ignored, and lim is not re-sampled.
- Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
- abort in any non-IDLE state:
  - next state is IDLE; the pipeline valid bits are cleared and idx is set to 0;
  - layer_done is not pulsed and mac_en is 0 from the next cycle on.
- An asynchronous reset mid-layer behaves like abort, but takes effect immediately.
- All outputs are registered or decoded from state/pipeline registers only; there is no combinational path from data_ready to rd_en.
- Throughput with no stalls, MEM_LATENCY=L, start sampled in cycle 0: CLEAR in cycle 1, ISSUE in cycles 2..lim+1, DRAIN for L cycles, layer_done in cycle lim+L+2.

Test Plan:
- max_input=65, L=1, data_ready=1 → acc_clear in cycle 1; rd_addr 0..64 in cycles 2..66; mac_en in cycles 3..67 with mac_idx 0..64; layer_done in cycle 68; busy low in cycle 69.
- max_input=17, data_ready low for 3 cycles at idx 5 → rd_addr holds at 5 for 4 cycles; mac_en shows a 3-cycle gap; still 17 mac_en pulses; layer_done is delayed by 3 cycles.
- max_input=0 → CLEAR then DONE; acc_clear at cycle 1, layer_done at cycle 2, no rd_en, no mac_en.
- L=3, max_input=9 → DRAIN lasts 3 cycles; last mac_en (idx 8) one cycle before layer_done in cycle 14.
- abort at idx 10 of a 65-input layer → IDLE next cycle; no layer_done; a new start afterwards runs cleanly from idx 0.
- start re-pulsed at idx 4 with max_input=9 while running 65 → ignored; the run completes 65 inputs. Reset asserted mid-ISSUE → all outputs 0 immediately.

Source files
------------

// File: rtl/ann_layer_sequencer_if.sv
// Controller/buffer/MAC handshake bundle of the ANN layer input sequencer.
interface ann_layer_sequencer_if #(
    parameter int unsigned ADDR_W = 7
) ();
    logic              start;
    logic [ADDR_W-1:0] max_input;
    logic              data_ready;
    logic              abort;
    logic              acc_clear;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mac_en;
    logic [ADDR_W-1:0] mac_idx;
    logic              busy;
    logic              layer_done;

    // Environment side: controller commands and buffer readiness.
    modport master (
        output start, max_input, data_ready, abort,
        input  acc_clear, rd_en, rd_addr, mac_en, mac_idx, busy, layer_done
    );

    // Sequencer side.
    modport slave (
        input  start, max_input, data_ready, abort,
        output acc_clear, rd_en, rd_addr, mac_en, mac_idx, busy, layer_done
    );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Per-layer input sequencer: clears accumulators, walks the shared read
// address 0..lim-1 under a ready handshake, and delays each accepted read
// by the memory latency to form the MAC enables.
module ann_layer_sequencer #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic                  clk,
    input logic                  n_rst,
    ann_layer_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] lim;
    logic [ADDR_W-1:0] lim_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              pipe_valid [MEM_LATENCY];
    logic [ADDR_W-1:0] pipe_idx   [MEM_LATENCY];

    // A read is taken whenever a request is up and the buffer is ready.
    assign accept = (state == ISSUE) && bus.data_ready;

    // State and counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            lim   <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            lim   <= lim_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, index and drain-counter logic; abort overrides everything.
    always_comb begin
        state_next = state;
        lim_next   = lim;
        idx_next   = idx;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CLEAR;
                    lim_next   = bus.max_input;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                state_next = (lim == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (accept) begin
                    // lim is non-zero here, so lim-1 cannot underflow.
                    if (idx == lim - ADDR_W'(1)) begin
                        state_next = DRAIN;
                        idx_next   = '0;
                        cnt_next   = CNT_W'(MEM_LATENCY - 1);
                    end else begin
                        idx_next = idx + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (bus.abort) begin
            state_next = IDLE;
            lim_next   = lim;
            idx_next   = '0;
        end
    end

    // Latency pipeline of {valid, idx}; keeps shifting through stalls.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_idx[i]   <= '0;
            end
        end else begin
            pipe_valid[0] <= accept && !bus.abort;
            pipe_idx[0]   <= idx;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                pipe_valid[i] <= pipe_valid[i-1] && !bus.abort;
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    // Outputs are decoded from state and pipeline registers only.
    assign bus.acc_clear  = (state == CLEAR);
    assign bus.rd_en      = (state == ISSUE);
    assign bus.rd_addr    = idx;
    assign bus.mac_en     = pipe_valid[MEM_LATENCY-1];
    assign bus.mac_idx    = pipe_valid[MEM_LATENCY-1] ? pipe_idx[MEM_LATENCY-1] : '0;
    assign bus.busy       = (state != IDLE);
    assign bus.layer_done = (state == DONE);
endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed bench for ann_layer_sequencer: one DUT with latency 1 and one
// with latency 3 share the same stimulus; each test checks one of them.
module tb_ann_layer_sequencer;
    localparam int unsigned ADDR_W = 7;
    localparam int NREC = 200;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic [ADDR_W-1:0] max_input;
    logic              data_ready;
    logic              abort;

    int tests_run;
    int tests_failed;

    ann_layer_sequencer_if #(.ADDR_W(ADDR_W)) bus1 ();
    ann_layer_sequencer_if #(.ADDR_W(ADDR_W)) bus3 ();

    assign bus1.start      = start;
    assign bus1.max_input  = max_input;
    assign bus1.data_ready = data_ready;
    assign bus1.abort      = abort;
    assign bus3.start      = start;
    assign bus3.max_input  = max_input;
    assign bus3.data_ready = data_ready;
    assign bus3.abort      = abort;

    ann_layer_sequencer #(.ADDR_W(ADDR_W), .MEM_LATENCY(1)) dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus1)
    );

    ann_layer_sequencer #(.ADDR_W(ADDR_W), .MEM_LATENCY(3)) dut3 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle record of one DUT's outputs; index = cycle after start.
    logic              rec_clr   [NREC];
    logic              rec_rd_en [NREC];
    logic [ADDR_W-1:0] rec_rd_addr [NREC];
    logic              rec_mac_en [NREC];
    logic [ADDR_W-1:0] rec_mac_idx [NREC];
    logic              rec_busy  [NREC];
    logic              rec_done  [NREC];
    logic              rec_dr    [NREC];

    // Summary of the last recorded run.
    int clr_first, clr_cnt, rd_first, rd_last, rd_acc, rd_bad;
    int mac_first, mac_last, mac_last_idx, mac_cnt, mac_bad, done_first, done_cnt;

    task automatic summarize(input int n);
        int exp_rd;
        int exp_mac;
        exp_rd = 0; exp_mac = 0;
        clr_first = -1; clr_cnt = 0; rd_first = -1; rd_last = -1; rd_acc = 0; rd_bad = 0;
        mac_first = -1; mac_last = -1; mac_last_idx = -1; mac_cnt = 0; mac_bad = 0;
        done_first = -1; done_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            if (rec_clr[k]) begin
                if (clr_first < 0) clr_first = k;
                clr_cnt++;
            end
            if (rec_rd_en[k]) begin
                if (rd_first < 0) rd_first = k;
                rd_last = k;
                if (int'(rec_rd_addr[k]) != exp_rd) rd_bad++;
                if (rec_dr[k]) begin
                    exp_rd++;
                    rd_acc++;
                end
            end
            if (rec_mac_en[k]) begin
                if (mac_first < 0) mac_first = k;
                mac_last = k;
                mac_last_idx = int'(rec_mac_idx[k]);
                if (int'(rec_mac_idx[k]) != exp_mac) mac_bad++;
                exp_mac++;
                mac_cnt++;
            end
            if (rec_done[k]) begin
                if (done_first < 0) done_first = k;
                done_cnt++;
            end
        end
    endtask

    // Pulse start (cycle 0) and record n cycles, applying optional stall,
    // abort and re-start stimulus at the given cycles (-1 disables).
    task automatic run_layer(input int sel, input int m, input int n,
                             input int stall_from, input int stall_len,
                             input int abort_at, input int restart_at);
        for (int k = 0; k < NREC; k++) begin
            rec_clr[k] = 1'b0; rec_rd_en[k] = 1'b0; rec_rd_addr[k] = '0; rec_mac_en[k] = 1'b0;
            rec_mac_idx[k] = '0; rec_busy[k] = 1'b0; rec_done[k] = 1'b0; rec_dr[k] = 1'b0;
        end
        @(negedge clk);
        start = 1'b1; max_input = ADDR_W'(m); data_ready = 1'b1; abort = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (sel == 0) begin
                rec_clr[k] = bus1.acc_clear; rec_rd_en[k] = bus1.rd_en; rec_rd_addr[k] = bus1.rd_addr;
                rec_mac_en[k] = bus1.mac_en; rec_mac_idx[k] = bus1.mac_idx;
                rec_busy[k] = bus1.busy; rec_done[k] = bus1.layer_done;
            end else begin
                rec_clr[k] = bus3.acc_clear; rec_rd_en[k] = bus3.rd_en; rec_rd_addr[k] = bus3.rd_addr;
                rec_mac_en[k] = bus3.mac_en; rec_mac_idx[k] = bus3.mac_idx;
                rec_busy[k] = bus3.busy; rec_done[k] = bus3.layer_done;
            end
            start      = (k == restart_at);
            max_input  = (k == restart_at) ? ADDR_W'(9) : ADDR_W'(m);
            data_ready = !(stall_from >= 0 && k >= stall_from && k < stall_from + stall_len);
            abort      = (k == abort_at);
            rec_dr[k]  = data_ready;
        end
        start = 1'b0; abort = 1'b0; data_ready = 1'b1;
        summarize(n);
    endtask

    task automatic test_reset();
        logic [2*ADDR_W+4:0] o1;
        logic [2*ADDR_W+4:0] o3;
        repeat (3) @(negedge clk);
        o1 = {bus1.acc_clear, bus1.rd_en, bus1.rd_addr, bus1.mac_en, bus1.mac_idx, bus1.busy, bus1.layer_done};
        o3 = {bus3.acc_clear, bus3.rd_en, bus3.rd_addr, bus3.mac_en, bus3.mac_idx, bus3.busy, bus3.layer_done};
        tests_run++; if (o1 !== '0) begin tests_failed++; $display("FAIL reset_outputs_l1: got %h expected 0", o1); end
        tests_run++; if (o3 !== '0) begin tests_failed++; $display("FAIL reset_outputs_l3: got %h expected 0", o3); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        o1 = {bus1.acc_clear, bus1.rd_en, bus1.rd_addr, bus1.mac_en, bus1.mac_idx, bus1.busy, bus1.layer_done};
        tests_run++; if (o1 !== '0) begin tests_failed++; $display("FAIL idle_after_reset: got %h expected 0", o1); end
    endtask

    task automatic test_basic_65();
        run_layer(0, 65, 75, -1, 0, -1, -1);
        tests_run++; if (clr_first != 1)  begin tests_failed++; $display("FAIL basic_clear_cycle: got %0d expected 1", clr_first); end
        tests_run++; if (clr_cnt != 1)    begin tests_failed++; $display("FAIL basic_clear_count: got %0d expected 1", clr_cnt); end
        tests_run++; if (rd_first != 2 || rd_last != 66) begin tests_failed++; $display("FAIL basic_rd_window: got %0d..%0d expected 2..66", rd_first, rd_last); end
        tests_run++; if (rd_acc != 65 || rd_bad != 0) begin tests_failed++; $display("FAIL basic_rd_seq: got %0d reads %0d bad expected 65 reads 0 bad", rd_acc, rd_bad); end
        tests_run++; if (mac_first != 3 || mac_last != 67) begin tests_failed++; $display("FAIL basic_mac_window: got %0d..%0d expected 3..67", mac_first, mac_last); end
        tests_run++; if (mac_cnt != 65 || mac_bad != 0) begin tests_failed++; $display("FAIL basic_mac_seq: got %0d pulses %0d bad expected 65 pulses 0 bad", mac_cnt, mac_bad); end
        tests_run++; if (done_first != 68 || done_cnt != 1) begin tests_failed++; $display("FAIL basic_done: got cycle %0d count %0d expected cycle 68 count 1", done_first, done_cnt); end
        tests_run++; if (rec_busy[68] !== 1'b1 || rec_busy[69] !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b%b expected 10", rec_busy[68], rec_busy[69]); end
    endtask

    task automatic test_stall();
        int hold;
        run_layer(0, 17, 30, 7, 3, -1, -1);
        hold = 0;
        for (int k = 7; k <= 10; k++) if (rec_rd_en[k] && rec_rd_addr[k] == ADDR_W'(5)) hold++;
        tests_run++; if (hold != 4) begin tests_failed++; $display("FAIL stall_addr_hold: got %0d cycles expected 4", hold); end
        tests_run++; if (rec_mac_en[7] !== 1'b1 || rec_mac_en[8] !== 1'b0 || rec_mac_en[9] !== 1'b0 || rec_mac_en[10] !== 1'b0)
            begin tests_failed++; $display("FAIL stall_mac_gap: got %b%b%b%b expected 1000", rec_mac_en[7], rec_mac_en[8], rec_mac_en[9], rec_mac_en[10]); end
        tests_run++; if (rec_mac_en[11] !== 1'b1 || rec_mac_idx[11] !== ADDR_W'(5)) begin tests_failed++; $display("FAIL stall_resume: got en %b idx %0d expected en 1 idx 5", rec_mac_en[11], rec_mac_idx[11]); end
        tests_run++; if (mac_cnt != 17 || mac_bad != 0 || rd_bad != 0) begin tests_failed++; $display("FAIL stall_seq: got %0d pulses %0d/%0d bad expected 17 pulses 0 bad", mac_cnt, mac_bad, rd_bad); end
        tests_run++; if (done_first != 23) begin tests_failed++; $display("FAIL stall_done: got %0d expected 23", done_first); end
    endtask

    task automatic test_zero();
        run_layer(0, 0, 8, -1, 0, -1, -1);
        tests_run++; if (clr_first != 1 || done_first != 2) begin tests_failed++; $display("FAIL zero_timing: got clear %0d done %0d expected clear 1 done 2", clr_first, done_first); end
        tests_run++; if (rd_first != -1 || mac_cnt != 0) begin tests_failed++; $display("FAIL zero_no_reads: got rd_first %0d macs %0d expected -1 and 0", rd_first, mac_cnt); end
        tests_run++; if (rec_busy[3] !== 1'b0) begin tests_failed++; $display("FAIL zero_busy: got %b expected 0", rec_busy[3]); end
    endtask

    task automatic test_latency3();
        run_layer(1, 9, 20, -1, 0, -1, -1);
        tests_run++; if (rd_last != 10 || rec_rd_en[11] !== 1'b0) begin tests_failed++; $display("FAIL l3_rd_end: got last %0d expected 10", rd_last); end
        tests_run++; if (mac_first != 5 || mac_cnt != 9 || mac_bad != 0) begin tests_failed++; $display("FAIL l3_mac_seq: got first %0d count %0d bad %0d expected 5 9 0", mac_first, mac_cnt, mac_bad); end
        tests_run++; if (mac_last != 13 || mac_last_idx != 8) begin tests_failed++; $display("FAIL l3_last_mac: got cycle %0d idx %0d expected 13 idx 8", mac_last, mac_last_idx); end
        tests_run++; if (done_first != 14 || !(rec_busy[13] === 1'b1 && rec_busy[12] === 1'b1 && rec_busy[11] === 1'b1))
            begin tests_failed++; $display("FAIL l3_done: got %0d expected 14", done_first); end
    endtask

    task automatic test_abort();
        run_layer(0, 65, 20, -1, 0, 12, -1);
        tests_run++; if (rec_busy[12] !== 1'b1 || rec_busy[13] !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got busy %b%b expected 10", rec_busy[12], rec_busy[13]); end
        tests_run++; if (mac_cnt != 10 || mac_last != 12 || rec_mac_en[13] !== 1'b0) begin tests_failed++; $display("FAIL abort_mac_stop: got %0d pulses last %0d expected 10 last 12", mac_cnt, mac_last); end
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        run_layer(0, 3, 10, -1, 0, -1, -1);
        tests_run++; if (rd_first != 2 || rd_acc != 3 || rd_bad != 0) begin tests_failed++; $display("FAIL abort_rerun_rd: got first %0d reads %0d bad %0d expected 2 3 0", rd_first, rd_acc, rd_bad); end
        tests_run++; if (mac_cnt != 3 || mac_bad != 0 || done_first != 6) begin tests_failed++; $display("FAIL abort_rerun_mac: got %0d pulses done %0d expected 3 done 6", mac_cnt, done_first); end
    endtask

    task automatic test_start_while_busy();
        run_layer(0, 65, 75, -1, 0, -1, 6);
        tests_run++; if (mac_cnt != 65 || mac_bad != 0 || rd_last != 66) begin tests_failed++; $display("FAIL restart_ignored: got %0d pulses rd_last %0d expected 65 rd_last 66", mac_cnt, rd_last); end
        tests_run++; if (done_first != 68 || done_cnt != 1) begin tests_failed++; $display("FAIL restart_done: got %0d count %0d expected 68 count 1", done_first, done_cnt); end
    endtask

    task automatic test_max_127();
        run_layer(0, 127, 135, -1, 0, -1, -1);
        tests_run++; if (mac_cnt != 127 || mac_bad != 0 || mac_last_idx != 126) begin tests_failed++; $display("FAIL max_mac: got %0d pulses last idx %0d expected 127 idx 126", mac_cnt, mac_last_idx); end
        tests_run++; if (done_first != 130 || rd_bad != 0) begin tests_failed++; $display("FAIL max_done: got %0d expected 130", done_first); end
    endtask

    task automatic test_reset_mid();
        logic [2*ADDR_W+4:0] o1;
        logic [2*ADDR_W+4:0] o3;
        @(negedge clk);
        start = 1'b1; max_input = ADDR_W'(65);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++; if (bus1.rd_en !== 1'b1 || bus1.rd_addr !== ADDR_W'(7)) begin tests_failed++; $display("FAIL mid_issue: got rd_en %b addr %0d expected 1 addr 7", bus1.rd_en, bus1.rd_addr); end
        #2 n_rst = 1'b0;
        #1;
        o1 = {bus1.acc_clear, bus1.rd_en, bus1.rd_addr, bus1.mac_en, bus1.mac_idx, bus1.busy, bus1.layer_done};
        o3 = {bus3.acc_clear, bus3.rd_en, bus3.rd_addr, bus3.mac_en, bus3.mac_idx, bus3.busy, bus3.layer_done};
        tests_run++; if (o1 !== '0 || o3 !== '0) begin tests_failed++; $display("FAIL async_reset: got %h/%h expected 0/0", o1, o3); end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (bus1.busy !== 1'b0 || bus1.mac_en !== 1'b0) begin tests_failed++; $display("FAIL reset_stays_idle: got busy %b mac %b expected 0 0", bus1.busy, bus1.mac_en); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        n_rst = 1'b0; start = 1'b0; max_input = '0; data_ready = 1'b1; abort = 1'b0;
        test_reset();
        test_basic_65();
        test_stall();
        test_zero();
        test_latency3();
        test_abort();
        test_start_while_busy();
        test_max_127();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
